dmem_loader: RTL and testbench

DMEM_LOADER -- requirements
Module: dmem_loader

---
 rtl/dmem_loader_pkg.sv | 39 +++
 rtl/dmem_loader_sat_counter16.sv | 36 +++
 rtl/dmem_loader.sv | 174 +++++++++++++++++
 tb/tb_dmem_loader.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_loader_pkg.sv
// -----------------------------------------------------------------------------
// dmem_loader_pkg
// Shared definitions for the data-memory loader, the CPU it feeds and its
// testbench: the loader FSM state encoding and the functions that derive the
// operand/result memory layout from the matrix dimensions.
//
// Layout (byte addresses, ascending):
//   0 .. M*N*4-1              matrix words, row-major, MSB byte first
//   M*N*4 .. LOAD_BYTES-1     vector words, MSB byte first
//   RES_BASE .. +RES_BYTES-1  result words, zeroed before the CPU starts
// -----------------------------------------------------------------------------
package dmem_loader_pkg;

   // Loader FSM encoding, kept as plain constants so older tools and the CPU
   // side can compare against the same values.
   localparam int         ST_W      = 3;
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_LOAD   = 3'd1;
   localparam logic [2:0] ST_CLEAR  = 3'd2;
   localparam logic [2:0] ST_START  = 3'd3;
   localparam logic [2:0] ST_RUN    = 3'd4;
   localparam logic [2:0] ST_FINISH = 3'd5;

   // Bytes streamed in: the M x N matrix followed by the N-element vector.
   function automatic int load_bytes(input int m, input int n);
      return m * n * 4 + n * 4;
   endfunction

   // Results sit directly after the operands.
   function automatic int res_base(input int m, input int n);
      return load_bytes(m, n);
   endfunction

   // One 32-bit result word per matrix row.
   function automatic int res_bytes(input int m);
      return m * 4;
   endfunction

endpackage

// File: rtl/dmem_loader_sat_counter16.sv
// -----------------------------------------------------------------------------
// sat_counter16
// 16-bit up counter with synchronous reset, synchronous clear and enable.
// Stops at 16'hFFFF instead of wrapping.
//
// Ports:
//   i_clk    clock, rising edge
//   i_srst   synchronous active-high reset
//   i_clr    synchronous clear (wins over enable)
//   i_en     count enable
//   o_count  current count
// -----------------------------------------------------------------------------
module sat_counter16 (
   input  logic        i_clk,
   input  logic        i_srst,
   input  logic        i_clr,
   input  logic        i_en,
   output logic [15:0] o_count
);

   logic [15:0] r_count;

   // NOTE: sequential state is updated with non-blocking assignments only, so
   // every flop samples its inputs from before the edge regardless of the
   // order in which always_ff blocks are evaluated.
   always_ff @(posedge i_clk) begin
      if (i_srst || i_clr) begin
         r_count <= '0;
      end else if (i_en && (r_count != 16'hFFFF)) begin
         r_count <= r_count + 16'd1;
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/dmem_loader.sv
// -----------------------------------------------------------------------------
// dmem_loader
// Streams matrix/vector operands into the CPU data memory, zeroes the result
// area, releases the CPU with a one-cycle start pulse and counts the cycles
// until the CPU reports completion.
//
// Ports:
//   CLOCK_50    clock, all logic on the rising edge
//   reset       synchronous active-high reset
//   load_req    one-cycle request to start a load (honoured in IDLE/FINISH)
//   in_valid    in_byte carries a valid byte
//   in_byte     operand byte stream, MSB byte of each word first
//   in_ready    loader accepts in_byte this cycle (LOAD only)
//   mem_we      byte write strobe to the data memory
//   mem_addr    byte write address
//   mem_wdata   byte write data
//   cpu_start   one-cycle pulse releasing the CPU
//   cpu_done    CPU end-of-program level, only looked at in RUN
//   busy        high in LOAD, CLEAR, START and RUN
//   finished    high in FINISH
//   run_cycles  cycles spent in RUN, saturating at 16'hFFFF
// -----------------------------------------------------------------------------
module dmem_loader
   import dmem_loader_pkg::*;
#(
   parameter int M      = 3,
   parameter int N      = 4,
   parameter int ADDR_W = 8
) (
   input  logic              CLOCK_50,
   input  logic              reset,
   input  logic              load_req,
   input  logic              in_valid,
   input  logic [7:0]        in_byte,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              cpu_start,
   input  logic              cpu_done,
   output logic              busy,
   output logic              finished,
   output logic [15:0]       run_cycles
);

   localparam int LOAD_BYTES = load_bytes(M, N);
   localparam int RES_BASE   = res_base(M, N);
   localparam int RES_BYTES  = res_bytes(M);

   localparam logic [ADDR_W-1:0] LOAD_LAST  = ADDR_W'(LOAD_BYTES - 1);
   localparam logic [ADDR_W-1:0] CLEAR_LAST = ADDR_W'(RES_BYTES - 1);
   localparam logic [ADDR_W-1:0] RES_BASE_A = ADDR_W'(RES_BASE);

   logic [ST_W-1:0]   r_state;
   logic [ADDR_W-1:0] r_cnt;      // byte index within LOAD or CLEAR

   logic              w_in_ready;
   logic              w_mem_we;
   logic [ADDR_W-1:0] w_mem_addr;
   logic [7:0]        w_mem_wdata;
   logic              w_cpu_start;
   logic              w_run;
   logic              w_cnt_clr;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (load_req) begin
                  r_state <= ST_LOAD;
                  r_cnt   <= '0;
               end
            end
            ST_LOAD: begin
               // Gaps (in_valid=0) simply hold the counter.
               if (in_valid) begin
                  if (r_cnt == LOAD_LAST) begin
                     r_state <= ST_CLEAR;
                     r_cnt   <= '0;
                  end else begin
                     r_cnt <= r_cnt + ADDR_W'(1);
                  end
               end
            end
            ST_CLEAR: begin
               if (r_cnt == CLEAR_LAST) begin
                  r_state <= ST_START;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + ADDR_W'(1);
               end
            end
            ST_START: begin
               r_state <= ST_RUN;
            end
            ST_RUN: begin
               if (cpu_done) begin
                  r_state <= ST_FINISH;
               end
            end
            ST_FINISH: begin
               if (load_req) begin
                  r_state <= ST_LOAD;
                  r_cnt   <= '0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   // ----------------------------------------------------- datapath outputs
   // Strobes are masked while reset is high so an abort in LOAD or CLEAR
   // cannot issue one last write on the reset cycle itself.
   // NOTE: every signal written in this always_comb receives a default first;
   // a path that leaves one unassigned would infer a latch.
   always_comb begin
      w_in_ready  = 1'b0;
      w_mem_we    = 1'b0;
      w_mem_addr  = r_cnt;
      w_mem_wdata = 8'h00;
      w_cpu_start = 1'b0;
      if (!reset) begin
         case (r_state)
            ST_LOAD: begin
               w_in_ready  = 1'b1;
               w_mem_we    = in_valid;
               w_mem_wdata = in_byte;
            end
            ST_CLEAR: begin
               w_mem_we   = 1'b1;
               w_mem_addr = RES_BASE_A + r_cnt;
            end
            ST_START: begin
               w_cpu_start = 1'b1;
            end
            default: begin
               w_in_ready = 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = w_in_ready;
   assign mem_we    = w_mem_we;
   assign mem_addr  = w_mem_addr;
   assign mem_wdata = w_mem_wdata;
   assign cpu_start = w_cpu_start;
   assign busy      = (r_state != ST_IDLE) && (r_state != ST_FINISH);
   assign finished  = (r_state == ST_FINISH);

   // ------------------------------------------------------ run-cycle count
   // The cycle on which cpu_done is seen is still a RUN cycle, so it counts.
   // The count survives in FINISH and is only cleared by a new load from
   // FINISH (or by reset).
   assign w_run     = (r_state == ST_RUN);
   assign w_cnt_clr = (r_state == ST_FINISH) && load_req;

   sat_counter16 u_run_cnt (
      .i_clk   (CLOCK_50),
      .i_srst  (reset),
      .i_clr   (w_cnt_clr),
      .i_en    (w_run),
      .o_count (run_cycles)
   );

endmodule

// File: tb/tb_dmem_loader.sv
// -----------------------------------------------------------------------------
// tb_dmem_loader
// Scoreboard bench for dmem_loader. Stimulus tasks push every memory write
// they expect (address, byte) into a queue; a negedge monitor pops and
// compares whenever mem_we is high. Run-cycle expectations come from the
// number of RUN cycles the bench itself holds cpu_done low.
// -----------------------------------------------------------------------------
module tb_dmem_loader;
   import dmem_loader_pkg::*;

   localparam int M      = 3;
   localparam int N      = 4;
   localparam int ADDR_W = 8;
   localparam int LB     = load_bytes(M, N);
   localparam int RB     = res_base(M, N);
   localparam int RS     = res_bytes(M);

   logic              clk = 1'b0;
   logic              reset;
   logic              load_req;
   logic              in_valid;
   logic [7:0]        in_byte;
   logic              in_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;
   logic              cpu_start;
   logic              cpu_done;
   logic              busy;
   logic              finished;
   logic [15:0]       run_cycles;

   dmem_loader #(.M(M), .N(N), .ADDR_W(ADDR_W)) dut (
      .CLOCK_50   (clk),
      .reset      (reset),
      .load_req   (load_req),
      .in_valid   (in_valid),
      .in_byte    (in_byte),
      .in_ready   (in_ready),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .cpu_start  (cpu_start),
      .cpu_done   (cpu_done),
      .busy       (busy),
      .finished   (finished),
      .run_cycles (run_cycles)
   );

   always #5 clk = ~clk;

   typedef struct {
      int addr;
      int data;
   } wr_t;

   wr_t exp_q[$];
   int  n_tests  = 0;
   int  n_fail   = 0;
   int  n_writes = 0;
   int  n_starts = 0;
   int  n_ready  = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: samples on the falling edge, away from the DUT edge.
   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         n_writes++;
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_write: addr 0x%0h data 0x%0h with empty queue",
                     mem_addr, mem_wdata);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            check("wr_addr", mem_addr, e.addr);
            check("wr_data", mem_wdata, e.data);
         end
      end
      if (cpu_start === 1'b1) n_starts++;
      if (in_ready === 1'b1) n_ready++;
   end

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_load();
      load_req = 1'b1;
      tick();
      load_req = 1'b0;
   endtask

   // Expected behaviour: k-th accepted byte lands at address k; after the last
   // one the result area RB..RB+RS-1 is zeroed. Returns the cycles spent
   // offering bytes (accepted bytes plus gap cycles).
   // mode 0: back-to-back, data=address; 1: gap between every byte,
   // data=address; 2: random gaps, random data, stray load_req pulses.
   task automatic load_stream(input int mode, output int load_cycles);
      int gaps;
      gaps = 0;
      for (int k = 0; k < LB; k++) begin
         int ng;
         ng = (mode == 1) ? ((k > 0) ? 1 : 0) :
              (mode == 2) ? $urandom_range(0, 3) : 0;
         repeat (ng) begin
            in_valid = 1'b0;
            in_byte  = 8'($urandom);
            load_req = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            gaps++;
            tick();
         end
         begin
            wr_t e;
            e.addr   = k;
            e.data   = (mode == 2) ? $urandom_range(0, 255) : (k & 8'hFF);
            in_valid = 1'b1;
            in_byte  = 8'(e.data);
            load_req = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            exp_q.push_back(e);
         end
         tick();
      end
      in_valid = 1'b0;
      load_req = 1'b0;
      for (int k = 0; k < RS; k++) begin
         wr_t e;
         e.addr = RB + k;
         e.data = 0;
         exp_q.push_back(e);
      end
      load_cycles = LB + gaps;
   endtask

   // Leaves the caller at the falling edge inside the START cycle.
   task automatic wait_start(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (cpu_start === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         n_tests++;
         n_fail++;
         $display("FAIL start_timeout: no cpu_start within 64 cycles");
      end
   endtask

   // Called at the falling edge of START. Holds RUN for n cycles, cpu_done
   // high on the n-th, then checks the FINISH state.
   task automatic run_phase(input int n);
      int exp_cnt;
      cpu_done = 1'b0;
      @(posedge clk);
      repeat (n - 1) @(posedge clk);
      #1;
      check("busy_in_run", busy, 1);
      check("no_early_finish", finished, 0);
      cpu_done = 1'b1;
      tick();
      cpu_done = 1'b0;
      @(negedge clk);
      exp_cnt = (n > 65535) ? 65535 : n;
      check("finished", finished, 1);
      check("busy_after_run", busy, 0);
      check("run_cycles", run_cycles, exp_cnt);
   endtask

   // One complete load/clear/start sequence starting from IDLE or FINISH.
   task automatic full_seq(input int mode, input int n_run, input bit done_early,
                           input bit from_finish);
      int wr0, st0, lc;
      bit ok;
      wr0      = n_writes;
      st0      = n_starts;
      cpu_done = done_early;
      n_ready  = 0;
      pulse_load();
      check("in_ready_in_load", in_ready, 1);
      if (from_finish) check("run_cycles_cleared", run_cycles, 0);
      load_stream(mode, lc);
      wait_start(ok);
      if (ok) begin
         check("writes_per_seq", n_writes - wr0, LB + RS);
         check("queue_drained", exp_q.size(), 0);
         check("load_cycles", n_ready, lc);
         check("finished_before_run", finished, 0);
         run_phase(n_run);
         check("one_start", n_starts - st0, 1);
      end
   endtask

   initial begin
      int wr0, st0;
      bit ok;
      reset    = 1'b1;
      load_req = 1'b0;
      in_valid = 1'b0;
      in_byte  = 8'h00;
      cpu_done = 1'b0;
      repeat (3) tick();
      check("rst_in_ready", in_ready, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_cpu_start", cpu_start, 0);
      check("rst_busy", busy, 0);
      check("rst_finished", finished, 0);
      check("rst_run_cycles", run_cycles, 0);
      reset = 1'b0;

      // cpu_done outside RUN is ignored.
      cpu_done = 1'b1;
      repeat (3) tick();
      cpu_done = 1'b0;
      check("idle_done_busy", busy, 0);
      check("idle_done_finished", finished, 0);

      // Back-to-back stream, 200-cycle run.
      full_seq(0, 200, 1'b0, 1'b0);

      // A later cpu_done pulse leaves the count alone.
      repeat (5) tick();
      cpu_done = 1'b1;
      repeat (2) tick();
      cpu_done = 1'b0;
      check("late_done_count", run_cycles, 200);
      check("late_done_finished", finished, 1);

      // Toggling in_valid, restarted from FINISH.
      full_seq(1, $urandom_range(1, 300), 1'b0, 1'b1);

      // Randomised gaps/data/stray load_req.
      for (int i = 0; i < 3; i++) full_seq(2, $urandom_range(1, 400), 1'b0, 1'b1);

      // Reset after 30 accepted bytes.
      repeat (2) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      wr0 = n_writes;
      pulse_load();
      for (int k = 0; k < 30; k++) begin
         wr_t e;
         e.addr   = k;
         e.data   = $urandom_range(0, 255);
         in_valid = 1'b1;
         in_byte  = 8'(e.data);
         exp_q.push_back(e);
         tick();
      end
      in_byte = 8'hA5;
      reset   = 1'b1;
      tick();
      check("abort_mem_we", mem_we, 0);
      check("abort_in_ready", in_ready, 0);
      check("abort_busy", busy, 0);
      reset    = 1'b0;
      in_valid = 1'b0;
      repeat (3) tick();
      check("abort_writes", n_writes - wr0, 30);
      check("abort_queue", exp_q.size(), 0);
      full_seq(0, 5, 1'b0, 1'b0);

      // Reset during RUN: back to IDLE, no further cpu_start.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      full_seq(0, 1, 1'b0, 1'b0);
      cpu_done = 1'b0;
      pulse_load();
      begin
         int lc;
         load_stream(0, lc);
      end
      wait_start(ok);
      @(posedge clk);
      repeat (10) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      st0 = n_starts;
      repeat (20) tick();
      check("run_reset_starts", n_starts - st0, 0);
      check("run_reset_busy", busy, 0);
      check("run_reset_count", run_cycles, 0);

      // cpu_done held high through LOAD/CLEAR, then a 70001-cycle RUN.
      full_seq(0, 70001, 1'b1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
